wide_bus_capture_pipe: RTL

WIDE_BUS_CAPTURE_PIPE -- requirements
Module: wide_bus_capture_pipe

---
 rtl/wide_bus_capture_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wide_bus_capture_pipe.sv
// wide_bus_capture_pipe
// Multi-stage registered pipeline for a wide tagged payload. Beats whose
// channel tag is out of range or disabled are accepted but discarded.
// Per-channel forwarded-beat counters and a drop counter saturate at all-ones.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high. out_valid, out_ch and out_data come
// straight from the last stage register and hold steady while
// out_valid && !out_ready. in_ready is the only combinational output. It
// depends on stage occupancy, out_ready and reset, and never on in_valid.
module wide_bus_capture_pipe #(
    parameter int DATA_W = 1024,
    parameter int LSB    = 0,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk_main_domain_100mhz_primary_oscillator,
    input  logic                          reset_system_wide_asynchronous_active_low_synchronized,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [CH_W-1:0]               in_ch,
    input  logic [DATA_W-1+LSB:LSB]       in_data,
    input  logic [NUM_CH-1:0]             ch_enable,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH_W-1:0]               out_ch,
    output logic [DATA_W-1+LSB:LSB]       out_data,
    output logic [NUM_CH*CNT_W-1:0]       ch_count,
    output logic [CNT_W-1:0]              drop_count
);

    logic                         clk;
    logic                         rst_n;
    logic [DEPTH-1:0]             stage_valid;
    logic [DEPTH-1:0]             stage_load;
    logic [DEPTH-1:0][CH_W-1:0]   stage_ch;
    logic [DEPTH-1:0][DATA_W-1:0] stage_data;
    logic [NUM_CH-1:0][CNT_W-1:0] ch_count_q;
    logic [CNT_W-1:0]             drop_count_q;
    logic                         ch_ok;
    logic                         in_fire;
    logic                         keep_beat;
    logic                         drop_beat;
    logic                         out_fire;

    assign clk   = clk_main_domain_100mhz_primary_oscillator;
    assign rst_n = reset_system_wide_asynchronous_active_low_synchronized;

    // Stage load enables ripple back from the output: a stage may load when it
    // is empty or its content moves on in the same cycle.
    always_comb begin
        logic ld_chain;
        ld_chain = !stage_valid[DEPTH-1] || out_ready;
        stage_load = '0;
        stage_load[DEPTH-1] = ld_chain;
        for (int s = DEPTH - 2; s >= 0; s--) begin
            ld_chain = !stage_valid[s] || ld_chain;
            stage_load[s] = ld_chain;
        end
    end

    // A beat is kept only if its tag names an existing, enabled channel.
    always_comb begin
        ch_ok = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (in_ch == CH_W'(k) && ch_enable[k]) begin
                ch_ok = 1'b1;
            end
        end
    end

    assign in_ready  = rst_n && stage_load[0];
    assign in_fire   = in_valid && in_ready;
    assign keep_beat = in_fire && ch_ok;
    assign drop_beat = in_fire && !ch_ok;
    assign out_valid = stage_valid[DEPTH-1];
    assign out_ch    = stage_ch[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];
    assign out_fire  = out_valid && out_ready;

    // Pipeline stages; payload registers only load when a real beat arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            stage_ch    <= '0;
            stage_data  <= '0;
        end else begin
            if (stage_load[0]) begin
                stage_valid[0] <= keep_beat;
                if (keep_beat) begin
                    stage_ch[0]   <= in_ch;
                    stage_data[0] <= in_data;
                end
            end
            for (int s = 1; s < DEPTH; s++) begin
                if (stage_load[s]) begin
                    stage_valid[s] <= stage_valid[s-1];
                    if (stage_valid[s-1]) begin
                        stage_ch[s]   <= stage_ch[s-1];
                        stage_data[s] <= stage_data[s-1];
                    end
                end
            end
        end
    end

    // Saturating counters: forwarded beats per channel and dropped beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            if (drop_beat && drop_count_q != '1) begin
                drop_count_q <= drop_count_q + CNT_W'(1);
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (out_fire && out_ch == CH_W'(k) && ch_count_q[k] != '1) begin
                    ch_count_q[k] <= ch_count_q[k] + CNT_W'(1);
                end
            end
        end
    end

    assign ch_count   = ch_count_q;
    assign drop_count = drop_count_q;

endmodule
